rf_fault_shutdown: RTL and testbench



---
 rtl/rf_safety_pkg.sv | 16 +
 rtl/amp_ramp_step.sv | 45 ++++
 rtl/rf_fault_shutdown.sv | 143 ++++++++++++++
 tb/tb_rf_fault_shutdown.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_safety_pkg.sv
// Shared types and defaults for the RF fault shutdown path.
package rf_safety_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_RAMP_DOWN = 2'd1,
        ST_MUTED     = 2'd2,
        ST_RAMP_UP   = 2'd3
    } rf_state_e;

    localparam int unsigned DEF_RAMP_STEP   = 256;
    localparam int unsigned DEF_STEP_DIV    = 4;
    localparam int unsigned DEF_HOLD_CYCLES = 1000;
    localparam int unsigned FAULT_CNT_W     = 8;

endpackage

// File: rtl/amp_ramp_step.sv
// Combinational saturating amplitude step toward a target, used for both ramp directions.
module amp_ramp_step #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RAMP_STEP = 256
) (
    input  logic [WIDTH-1:0] amp_cur,
    input  logic [WIDTH-1:0] target,
    input  logic             tick,
    input  logic             dir_up,
    output logic [WIDTH-1:0] amp_next_c
);

    localparam int unsigned EXT_W = WIDTH + 1;
    localparam logic [EXT_W-1:0] STEP_EXT = EXT_W'(RAMP_STEP);

    logic [EXT_W-1:0] cur_ext;
    logic [EXT_W-1:0] tgt_ext;
    logic [EXT_W-1:0] sum_ext;
    logic [EXT_W-1:0] floor_ext;

    // One extra bit keeps the add and the compare free of wraparound.
    assign cur_ext   = EXT_W'(amp_cur);
    assign tgt_ext   = EXT_W'(target);
    assign sum_ext   = cur_ext + STEP_EXT;
    assign floor_ext = tgt_ext + STEP_EXT;

    // Step toward the target; a target on the wrong side is taken immediately.
    always_comb begin
        amp_next_c = amp_cur;
        if (dir_up) begin
            if (tgt_ext < cur_ext) begin
                amp_next_c = target;
            end else if (tick) begin
                amp_next_c = (sum_ext > tgt_ext) ? target : WIDTH'(sum_ext);
            end
        end else begin
            if (tgt_ext > cur_ext) begin
                amp_next_c = target;
            end else if (tick) begin
                amp_next_c = (cur_ext > floor_ext) ? WIDTH'(cur_ext - STEP_EXT) : target;
            end
        end
    end

endmodule

// File: rtl/rf_fault_shutdown.sv
// Ramps TX amplitude down on a watchdog fault, holds muted, ramps back up after host re-arm.
module rf_fault_shutdown
    import rf_safety_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned RAMP_STEP   = DEF_RAMP_STEP,
    parameter int unsigned STEP_DIV    = DEF_STEP_DIV,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   force_reset,
    input  logic                   rearm,
    input  logic [WIDTH-1:0]       amp_in,
    output logic [WIDTH-1:0]       amp_out,
    output logic                   rf_enable,
    output logic [1:0]             state_out,
    output logic                   shutdown_active,
    output logic [FAULT_CNT_W-1:0] fault_count
);

    localparam int unsigned DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DIV_W-1:0]       DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0]      HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [FAULT_CNT_W-1:0] FAULT_MAX = '1;

    rf_state_e              state_q, state_d;
    logic [WIDTH-1:0]       amp_q, amp_d;
    logic                   rf_en_q, rf_en_d;
    logic                   shdn_q, shdn_d;
    logic [FAULT_CNT_W-1:0] fault_q, fault_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;

    logic                   tick_c;
    logic [DIV_W-1:0]       div_next_c;
    logic [FAULT_CNT_W-1:0] fault_inc_c;
    logic                   ramp_up_c;
    logic [WIDTH-1:0]       ramp_tgt_c;
    logic [WIDTH-1:0]       ramp_next_c;

    assign tick_c      = (div_q == DIV_LAST);
    assign div_next_c  = tick_c ? '0 : div_q + DIV_W'(1);
    assign fault_inc_c = (fault_q == FAULT_MAX) ? fault_q : fault_q + FAULT_CNT_W'(1);
    assign ramp_up_c   = (state_q == ST_RAMP_UP);
    assign ramp_tgt_c  = ramp_up_c ? amp_in : '0;

    // Shared ramp arithmetic: toward amp_in when ramping up, toward zero when ramping down.
    amp_ramp_step #(
        .WIDTH     (WIDTH),
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
        .amp_cur    (amp_q),
        .target     (ramp_tgt_c),
        .tick       (tick_c),
        .dir_up     (ramp_up_c),
        .amp_next_c (ramp_next_c)
    );

    // Next-state and registered-output logic; divider and hold counter clear on any transition.
    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        rf_en_d = rf_en_q;
        fault_d = fault_q;
        div_d   = '0;
        hold_d  = '0;
        unique case (state_q)
            ST_RUN: begin
                amp_d   = amp_in;
                rf_en_d = 1'b1;
                if (force_reset) begin
                    state_d = ST_RAMP_DOWN;
                    fault_d = fault_inc_c;
                end
            end
            ST_RAMP_DOWN: begin
                if (amp_q == '0) begin
                    state_d = ST_MUTED;
                    rf_en_d = 1'b0;
                end else begin
                    amp_d = ramp_next_c;
                    div_d = div_next_c;
                end
            end
            ST_MUTED: begin
                amp_d   = '0;
                rf_en_d = 1'b0;
                hold_d  = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
                if ((hold_q == HOLD_MAX) && rearm && !force_reset) begin
                    state_d = ST_RAMP_UP;
                    rf_en_d = 1'b1;
                    hold_d  = '0;
                end
            end
            ST_RAMP_UP: begin
                rf_en_d = 1'b1;
                if (force_reset) begin
                    state_d = ST_RAMP_DOWN;
                    fault_d = fault_inc_c;
                end else if (amp_q == amp_in) begin
                    state_d = ST_RUN;
                end else begin
                    amp_d = ramp_next_c;
                    div_d = div_next_c;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        shdn_d = (state_d != ST_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            amp_q   <= '0;
            rf_en_q <= 1'b1;
            shdn_q  <= 1'b0;
            fault_q <= '0;
            div_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            amp_q   <= amp_d;
            rf_en_q <= rf_en_d;
            shdn_q  <= shdn_d;
            fault_q <= fault_d;
            div_q   <= div_d;
            hold_q  <= hold_d;
        end
    end

    assign amp_out         = amp_q;
    assign rf_enable       = rf_en_q;
    assign state_out       = state_q;
    assign shutdown_active = shdn_q;
    assign fault_count     = fault_q;

endmodule

// File: tb/tb_rf_fault_shutdown.sv
// Directed self-checking bench for rf_fault_shutdown.
module tb_rf_fault_shutdown;

    logic        clk;
    logic        rst;
    logic        force_reset;
    logic        rearm;
    logic [15:0] amp_in;
    logic [15:0] amp_out;
    logic        rf_enable;
    logic [1:0]  state_out;
    logic        shutdown_active;
    logic [7:0]  fault_count;

    logic        s_force;
    logic        s_rearm;
    logic [15:0] s_amp_in;
    logic [15:0] s_amp_out;
    logic        s_rf_enable;
    logic [1:0]  s_state;
    logic        s_shdn;
    logic [7:0]  s_fault;

    int n_checks;
    int n_fail;

    rf_fault_shutdown #(
        .WIDTH(16), .RAMP_STEP(256), .STEP_DIV(4), .HOLD_CYCLES(1000)
    ) dut (
        .clk(clk), .rst(rst), .force_reset(force_reset), .rearm(rearm),
        .amp_in(amp_in), .amp_out(amp_out), .rf_enable(rf_enable),
        .state_out(state_out), .shutdown_active(shutdown_active),
        .fault_count(fault_count)
    );

    // Short-hold instance for the fault-count saturation run.
    rf_fault_shutdown #(
        .WIDTH(16), .RAMP_STEP(256), .STEP_DIV(1), .HOLD_CYCLES(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .force_reset(s_force), .rearm(s_rearm),
        .amp_in(s_amp_in), .amp_out(s_amp_out), .rf_enable(s_rf_enable),
        .state_out(s_state), .shutdown_active(s_shdn),
        .fault_count(s_fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_main_state(input logic [1:0] st, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc; i++) begin
            if (state_out == st) break;
            step(1);
        end
        check_eq(tag, 32'(state_out), 32'(st));
    endtask

    task automatic wait_main_amp(input logic [15:0] a, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc; i++) begin
            if (amp_out == a) break;
            step(1);
        end
        check_eq(tag, 32'(amp_out), 32'(a));
    endtask

    task automatic wait_sat_state(input logic [1:0] st, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc; i++) begin
            if (s_state == st) break;
            step(1);
        end
        check_eq(tag, 32'(s_state), 32'(st));
    endtask

    task automatic sat_fault();
        s_force = 1'b1;
        step(1);
        s_force = 1'b0;
        s_rearm = 1'b1;
        wait_sat_state(2'd0, 20, "sat_back_to_run");
        s_rearm = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        clk         = 1'b0;
        rst         = 1'b1;
        force_reset = 1'b0;
        rearm       = 1'b0;
        amp_in      = 16'h1000;
        s_force     = 1'b0;
        s_rearm     = 1'b0;
        s_amp_in    = 16'h0000;

        // 1: reset values, then RUN tracking with one-cycle latency
        step(2);
        check_eq("rst_amp",   32'(amp_out), 32'h0);
        check_eq("rst_state", 32'(state_out), 32'd0);
        check_eq("rst_rfen",  32'(rf_enable), 32'd1);
        check_eq("rst_shdn",  32'(shutdown_active), 32'd0);
        check_eq("rst_fault", 32'(fault_count), 32'd0);
        rst = 1'b0;
        step(1);
        check_eq("run_track", 32'(amp_out), 32'h1000);

        // 2: one-cycle fault pulse, ramp down 256 per 4 cycles
        force_reset = 1'b1;
        step(1);
        force_reset = 1'b0;
        check_eq("rd_state",  32'(state_out), 32'd1);
        check_eq("rd_amp0",   32'(amp_out), 32'h1000);
        check_eq("rd_fault",  32'(fault_count), 32'd1);
        check_eq("rd_shdn",   32'(shutdown_active), 32'd1);
        check_eq("rd_rfen",   32'(rf_enable), 32'd1);
        step(3);
        check_eq("rd_pre_tick", 32'(amp_out), 32'h1000);
        step(1);
        check_eq("rd_tick1",  32'(amp_out), 32'h0F00);
        step(60);
        check_eq("rd_zero",   32'(amp_out), 32'h0);
        check_eq("rd_zero_st", 32'(state_out), 32'd1);
        step(1);
        check_eq("mute_state", 32'(state_out), 32'd2);
        check_eq("mute_rfen",  32'(rf_enable), 32'd0);

        // 3: early rearm discarded, rearm honoured only at full hold
        step(499);
        rearm = 1'b1;
        step(1);
        rearm = 1'b0;
        check_eq("early_rearm", 32'(state_out), 32'd2);
        step(499);
        rearm = 1'b1;
        step(1);
        check_eq("rearm_hold999", 32'(state_out), 32'd2);
        step(1);
        rearm = 1'b0;
        check_eq("ru_state", 32'(state_out), 32'd3);
        check_eq("ru_rfen",  32'(rf_enable), 32'd1);
        check_eq("ru_amp0",  32'(amp_out), 32'h0);
        step(3);
        check_eq("ru_pre_tick", 32'(amp_out), 32'h0);
        step(1);
        check_eq("ru_tick1", 32'(amp_out), 32'h0100);
        step(60);
        check_eq("ru_top",    32'(amp_out), 32'h1000);
        check_eq("ru_top_st", 32'(state_out), 32'd3);
        step(1);
        check_eq("ru_to_run", 32'(state_out), 32'd0);
        check_eq("ru_run_shdn", 32'(shutdown_active), 32'd0);

        // 4: fault during RAMP_UP at 0x0800, then force+rearm held in MUTED
        force_reset = 1'b1;
        step(1);
        force_reset = 1'b0;
        check_eq("f2_count", 32'(fault_count), 32'd2);
        wait_main_state(2'd2, 100, "f2_muted");
        rearm = 1'b1;
        wait_main_state(2'd3, 1100, "f2_rampup");
        rearm = 1'b0;
        wait_main_amp(16'h0800, 100, "f2_amp800");
        force_reset = 1'b1;
        step(1);
        force_reset = 1'b0;
        check_eq("f3_state", 32'(state_out), 32'd1);
        check_eq("f3_amp",   32'(amp_out), 32'h0800);
        check_eq("f3_count", 32'(fault_count), 32'd3);
        step(4);
        check_eq("f3_tick1", 32'(amp_out), 32'h0700);
        wait_main_state(2'd2, 100, "f3_muted");
        force_reset = 1'b1;
        rearm       = 1'b1;
        step(1100);
        check_eq("hold_force_st", 32'(state_out), 32'd2);
        check_eq("hold_force_rf", 32'(rf_enable), 32'd0);
        check_eq("hold_force_amp", 32'(amp_out), 32'h0);
        force_reset = 1'b0;
        step(1);
        rearm = 1'b0;
        check_eq("release_ru", 32'(state_out), 32'd3);

        // 5: amp_in drops below amp_out during RAMP_UP
        wait_main_amp(16'h0C00, 100, "ru_amp_c00");
        amp_in = 16'h0400;
        step(1);
        check_eq("drop_amp", 32'(amp_out), 32'h0400);
        check_eq("drop_st",  32'(state_out), 32'd3);
        step(1);
        check_eq("drop_run", 32'(state_out), 32'd0);
        step(1);
        check_eq("drop_track", 32'(amp_out), 32'h0400);

        // 6a: fault counter saturation
        for (int i = 0; i < 254; i++) sat_fault();
        check_eq("sat_254", 32'(s_fault), 32'd254);
        sat_fault();
        check_eq("sat_255", 32'(s_fault), 32'd255);
        sat_fault();
        check_eq("sat_hold", 32'(s_fault), 32'd255);

        // 6b: reset in the middle of RAMP_DOWN
        force_reset = 1'b1;
        step(1);
        force_reset = 1'b0;
        step(5);
        check_eq("pre_rst_st", 32'(state_out), 32'd1);
        rst = 1'b1;
        step(1);
        check_eq("mid_rst_st",    32'(state_out), 32'd0);
        check_eq("mid_rst_amp",   32'(amp_out), 32'h0);
        check_eq("mid_rst_fault", 32'(fault_count), 32'd0);
        check_eq("mid_rst_rfen",  32'(rf_enable), 32'd1);
        check_eq("mid_rst_shdn",  32'(shutdown_active), 32'd0);
        rst = 1'b0;
        step(1);
        check_eq("post_rst_track", 32'(amp_out), 32'h0400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
